vram_fill_arbiter: RTL and testbench

Write-port controller for the 32x32, 3-bit video memory. Shares the single video-memory write port between two sources. The CPU single-cycle write (WVM) has strict priority. A hardware rectangle-fill engine writes one cell per free cycle. The block sits between the CPU datapath and the video memory write inputs, and drives write enable, address and data from registers.

---
 rtl/vram_fill_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_vram_fill_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_fill_arbiter.sv
// vram_fill_arbiter: write-port controller for the 32x32 x 3-bit video memory.
// Shares the single write port between CPU single-cycle writes (strict
// priority) and a row-major rectangle-fill engine that writes one cell per
// free cycle. All outputs are registered.
//
// Ports:
//   Clock, Reset            rising-edge clock, async active-low reset
//   iCpuWrite/Addr/Color    CPU write request, address {y,x}, colour
//   iFillStart/Abort        start a fill / cancel the fill in progress
//   iFillX0/Y0/X1/Y1        inclusive rectangle corners
//   iFillColor              fill colour
//   oFillBusy               fill engine active
//   oFillDone               one-cycle pulse with the last fill write
//   oFillErr                one-cycle pulse on a rejected start
//   oVramWrite/Addr/Data    video memory write port
//
// Build option: FILL_SWAP_EN -- when defined, reversed corners are swapped
// per axis at latch time instead of being rejected; oFillErr stays 0.
module vram_fill_arbiter #(
    parameter int unsigned COLOR_W = 3,
    parameter int unsigned COORD_W = 5,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iCpuWrite,
    input  logic [ADDR_W-1:0]  iCpuAddr,
    input  logic [COLOR_W-1:0] iCpuColor,
    input  logic               iFillStart,
    input  logic               iFillAbort,
    input  logic [COORD_W-1:0] iFillX0,
    input  logic [COORD_W-1:0] iFillY0,
    input  logic [COORD_W-1:0] iFillX1,
    input  logic [COORD_W-1:0] iFillY1,
    input  logic [COLOR_W-1:0] iFillColor,
    output logic               oFillBusy,
    output logic               oFillDone,
    output logic               oFillErr,
    output logic               oVramWrite,
    output logic [ADDR_W-1:0]  oVramAddr,
    output logic [COLOR_W-1:0] oVramData
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [COORD_W-1:0] x0_q, x0_d, x1_q, x1_d;
    logic [COORD_W-1:0] y0_q, y0_d, y1_q, y1_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [COLOR_W-1:0] color_q, color_d;

    logic               vram_write_q, vram_write_d;
    logic [ADDR_W-1:0]  vram_addr_q, vram_addr_d;
    logic [COLOR_W-1:0] vram_data_q, vram_data_d;
    logic               fill_busy_q, fill_busy_d;
    logic               fill_done_q, fill_done_d;
    logic               fill_err_q, fill_err_d;

    logic               rev_x, rev_y, start_bad;
    logic [COORD_W-1:0] sx0, sx1, sy0, sy1;

    // Corner normalisation / validation of the incoming start request
    always_comb begin
        rev_x = (iFillX1 < iFillX0);
        rev_y = (iFillY1 < iFillY0);
`ifdef FILL_SWAP_EN
        sx0       = rev_x ? iFillX1 : iFillX0;
        sx1       = rev_x ? iFillX0 : iFillX1;
        sy0       = rev_y ? iFillY1 : iFillY0;
        sy1       = rev_y ? iFillY0 : iFillY1;
        start_bad = 1'b0;
`else
        sx0       = iFillX0;
        sx1       = iFillX1;
        sy0       = iFillY0;
        sy1       = iFillY1;
        start_bad = rev_x | rev_y;
`endif
    end

    // Next-state, arbitration and fill pointer update
    always_comb begin
        state_d      = state_q;
        x0_d         = x0_q;
        x1_d         = x1_q;
        y0_d         = y0_q;
        y1_d         = y1_q;
        x_d          = x_q;
        y_d          = y_q;
        color_d      = color_q;
        vram_write_d = 1'b0;
        vram_addr_d  = '0;
        vram_data_d  = '0;
        fill_busy_d  = fill_busy_q;
        fill_done_d  = 1'b0;
        fill_err_d   = 1'b0;

        // CPU always wins the port
        if (iCpuWrite) begin
            vram_write_d = 1'b1;
            vram_addr_d  = iCpuAddr;
            vram_data_d  = iCpuColor;
        end

        case (state_q)
            ST_IDLE: begin
                // A simultaneous abort cancels the start outright
                if (iFillStart && !iFillAbort) begin
                    if (start_bad) begin
                        fill_err_d = 1'b1;
                    end else begin
                        x0_d        = sx0;
                        x1_d        = sx1;
                        y0_d        = sy0;
                        y1_d        = sy1;
                        x_d         = sx0;
                        y_d         = sy0;
                        color_d     = iFillColor;
                        fill_busy_d = 1'b1;
                        state_d     = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (iFillAbort) begin
                    fill_busy_d = 1'b0;
                    state_d     = ST_IDLE;
                end else if (!iCpuWrite) begin
                    vram_write_d = 1'b1;
                    vram_addr_d  = ADDR_W'({y_q, x_q});
                    vram_data_d  = color_q;
                    // Row-major advance; pointer never passes X1/Y1
                    if (x_q == x1_q) begin
                        x_d = x0_q;
                        if (y_q == y1_q) begin
                            fill_busy_d = 1'b0;
                            fill_done_d = 1'b1;
                            state_d     = ST_IDLE;
                        end else begin
                            y_d = y_q + COORD_W'(1);
                        end
                    end else begin
                        x_d = x_q + COORD_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            x0_q         <= '0;
            x1_q         <= '0;
            y0_q         <= '0;
            y1_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            color_q      <= '0;
            vram_write_q <= 1'b0;
            vram_addr_q  <= '0;
            vram_data_q  <= '0;
            fill_busy_q  <= 1'b0;
            fill_done_q  <= 1'b0;
            fill_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            x0_q         <= x0_d;
            x1_q         <= x1_d;
            y0_q         <= y0_d;
            y1_q         <= y1_d;
            x_q          <= x_d;
            y_q          <= y_d;
            color_q      <= color_d;
            vram_write_q <= vram_write_d;
            vram_addr_q  <= vram_addr_d;
            vram_data_q  <= vram_data_d;
            fill_busy_q  <= fill_busy_d;
            fill_done_q  <= fill_done_d;
            fill_err_q   <= fill_err_d;
        end
    end

    assign oVramWrite = vram_write_q;
    assign oVramAddr  = vram_addr_q;
    assign oVramData  = vram_data_q;
    assign oFillBusy  = fill_busy_q;
    assign oFillDone  = fill_done_q;
    assign oFillErr   = fill_err_q;

endmodule

// File: tb/tb_vram_fill_arbiter.sv
// Self-checking bench for vram_fill_arbiter: a scoreboard queue of expected
// video-memory writes is checked on every write the DUT issues, driven by a
// table of fill rectangles plus hand-written CPU/collision/abort/reset cases.
// Build with +define+FILL_SWAP_EN to match a swap-enabled DUT.
module tb_vram_fill_arbiter;

    logic       Clock;
    logic       Reset;
    logic       iCpuWrite;
    logic [9:0] iCpuAddr;
    logic [2:0] iCpuColor;
    logic       iFillStart;
    logic       iFillAbort;
    logic [4:0] iFillX0, iFillY0, iFillX1, iFillY1;
    logic [2:0] iFillColor;
    logic       oFillBusy, oFillDone, oFillErr, oVramWrite;
    logic [9:0] oVramAddr;
    logic [2:0] oVramData;

    vram_fill_arbiter dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .iCpuWrite  (iCpuWrite),
        .iCpuAddr   (iCpuAddr),
        .iCpuColor  (iCpuColor),
        .iFillStart (iFillStart),
        .iFillAbort (iFillAbort),
        .iFillX0    (iFillX0),
        .iFillY0    (iFillY0),
        .iFillX1    (iFillX1),
        .iFillY1    (iFillY1),
        .iFillColor (iFillColor),
        .oFillBusy  (oFillBusy),
        .oFillDone  (oFillDone),
        .oFillErr   (oFillErr),
        .oVramWrite (oVramWrite),
        .oVramAddr  (oVramAddr),
        .oVramData  (oVramData)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [9:0] addr;
        logic [2:0] data;
        logic       done;
    } wr_t;

    typedef struct {
        logic [4:0] x0, y0, x1, y1;
        logic [2:0] color;
        int         exp_writes;
        logic       exp_err;
    } fill_vec_t;

    wr_t sb[$];
    int  n_cmp = 0;
    int  n_fail = 0;
    int  writes_seen = 0;
    int  done_seen = 0;
    int  err_seen = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: every write must match the head of the scoreboard
    always @(negedge Clock) begin
        if (Reset) begin
            if (oVramWrite) begin
                writes_seen++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                             oVramAddr, oVramData);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    check("wr_addr", oVramAddr, e.addr);
                    check("wr_data", oVramData, e.data);
                    check("wr_done", oFillDone, e.done);
                end
            end else if (oFillDone) begin
                n_cmp++;
                n_fail++;
                $display("FAIL done_without_write: got done 1, expected 0");
            end
            if (oFillDone) done_seen++;
            if (oFillErr)  err_seen++;
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic push_wr(input logic [9:0] a, input logic [2:0] d, input logic dn);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.done = dn;
        sb.push_back(e);
    endtask

    task automatic set_rect(input logic [4:0] x0, input logic [4:0] y0,
                            input logic [4:0] x1, input logic [4:0] y1,
                            input logic [2:0] c);
        iFillX0 = x0; iFillY0 = y0; iFillX1 = x1; iFillY1 = y1; iFillColor = c;
    endtask

    // Spec-level model: row-major cells of the (optionally normalised) rectangle
    task automatic push_rect(input int x0, input int y0, input int x1, input int y1,
                             input logic [2:0] c);
        int xl, xh, yl, yh;
        xl = x0; xh = x1; yl = y0; yh = y1;
`ifdef FILL_SWAP_EN
        if (x1 < x0) begin xl = x1; xh = x0; end
        if (y1 < y0) begin yl = y1; yh = y0; end
`endif
        if (xh < xl || yh < yl) return;
        for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++)
                push_wr(10'(y * 32 + x), c, (x == xh && y == yh));
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check(name, sb.size(), 0);
        tick();
        tick();
    endtask

    fill_vec_t vecs[8];

    initial begin
        int w0, d0, e0, cnt;

        vecs[0] = '{x0: 0,  y0: 0,  x1: 0,  y1: 0,  color: 1, exp_writes: 1,  exp_err: 0};
        vecs[1] = '{x0: 2,  y0: 3,  x1: 4,  y1: 4,  color: 6, exp_writes: 6,  exp_err: 0};
        vecs[2] = '{x0: 31, y0: 31, x1: 31, y1: 31, color: 7, exp_writes: 1,  exp_err: 0};
        vecs[3] = '{x0: 28, y0: 30, x1: 31, y1: 31, color: 2, exp_writes: 8,  exp_err: 0};
        vecs[4] = '{x0: 0,  y0: 5,  x1: 0,  y1: 7,  color: 3, exp_writes: 3,  exp_err: 0};
        vecs[5] = '{x0: 0,  y0: 0,  x1: 31, y1: 0,  color: 2, exp_writes: 32, exp_err: 0};
`ifdef FILL_SWAP_EN
        vecs[6] = '{x0: 5,  y0: 0,  x1: 1,  y1: 0,  color: 4, exp_writes: 5,  exp_err: 0};
        vecs[7] = '{x0: 3,  y0: 9,  x1: 3,  y1: 2,  color: 5, exp_writes: 8,  exp_err: 0};
`else
        vecs[6] = '{x0: 5,  y0: 0,  x1: 1,  y1: 0,  color: 4, exp_writes: 0,  exp_err: 1};
        vecs[7] = '{x0: 3,  y0: 9,  x1: 3,  y1: 2,  color: 5, exp_writes: 0,  exp_err: 1};
`endif

        Reset = 1'b0;
        iCpuWrite = 0; iCpuAddr = 0; iCpuColor = 0;
        iFillStart = 0; iFillAbort = 0;
        set_rect(0, 0, 0, 0, 0);
        #12;
        check("rst_write", oVramWrite, 0);
        check("rst_addr",  oVramAddr, 0);
        check("rst_data",  oVramData, 0);
        check("rst_busy",  oFillBusy, 0);
        check("rst_done",  oFillDone, 0);
        check("rst_err",   oFillErr, 0);
        Reset = 1'b1;
        tick();
        tick();

        // CPU write: one cycle, next cycle after sampling
        iCpuWrite = 1; iCpuAddr = 10'h123; iCpuColor = 3'd5;
        push_wr(10'h123, 3'd5, 1'b0);
        tick();
        iCpuWrite = 0;
        check("cpu_write_valid", oVramWrite, 1);
        tick();
        check("cpu_write_one_cycle", oVramWrite, 0);
        wait_drain("cpu_drain");

        // Fill (2,3)-(4,4) with explicit addresses and latency check
        push_wr(10'h062, 6, 0); push_wr(10'h063, 6, 0); push_wr(10'h064, 6, 0);
        push_wr(10'h082, 6, 0); push_wr(10'h083, 6, 0); push_wr(10'h084, 6, 1);
        set_rect(2, 3, 4, 4, 6);
        iFillStart = 1;
        tick();
        iFillStart = 0;
        check("fill_busy_n1", oFillBusy, 1);
        check("fill_no_write_n1", oVramWrite, 0);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!oFillDone && cnt < 20);
        check("fill_done_latency", cnt, 6);
        check("fill_busy_low_at_done", oFillBusy, 0);
        tick();
        check("fill_done_one_cycle", oFillDone, 0);
        wait_drain("fill_drain");

        // Collision: CPU write on the edge of the third fill cell
        push_wr(10'h062, 6, 0); push_wr(10'h063, 6, 0); push_wr(10'h3FF, 1, 0);
        push_wr(10'h064, 6, 0); push_wr(10'h082, 6, 0); push_wr(10'h083, 6, 0);
        push_wr(10'h084, 6, 1);
        w0 = writes_seen;
        iFillStart = 1;
        tick();
        iFillStart = 0;
        tick();
        tick();
        iCpuWrite = 1; iCpuAddr = 10'h3FF; iCpuColor = 1;
        tick();
        iCpuWrite = 0;
        wait_drain("collision_drain");
        check("collision_write_count", writes_seen - w0, 7);

        // Table-driven fills
        for (int i = 0; i < 8; i++) begin
            w0 = writes_seen; d0 = done_seen; e0 = err_seen;
            push_rect(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].color);
            set_rect(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].color);
            iFillStart = 1;
            tick();
            iFillStart = 0;
            check($sformatf("vec%0d_err", i), oFillErr, vecs[i].exp_err);
            check($sformatf("vec%0d_busy", i), oFillBusy, !vecs[i].exp_err);
            wait_drain($sformatf("vec%0d_drain", i));
            check($sformatf("vec%0d_writes", i), writes_seen - w0, vecs[i].exp_writes);
            check($sformatf("vec%0d_dones", i), done_seen - d0, (vecs[i].exp_writes > 0) ? 1 : 0);
            check($sformatf("vec%0d_err_pulses", i), err_seen - e0, vecs[i].exp_err);
            check($sformatf("vec%0d_busy_end", i), oFillBusy, 0);
        end

        // Abort after two fill writes
        w0 = writes_seen; d0 = done_seen;
        push_wr(10'h062, 6, 0); push_wr(10'h063, 6, 0);
        set_rect(2, 3, 4, 4, 6);
        iFillStart = 1;
        tick();
        iFillStart = 0;
        tick();
        tick();
        iFillAbort = 1;
        tick();
        iFillAbort = 0;
        check("abort_busy_falls", oFillBusy, 0);
        check("abort_no_write", oVramWrite, 0);
        for (int k = 0; k < 8; k++) tick();
        check("abort_writes", writes_seen - w0, 2);
        check("abort_no_done", done_seen - d0, 0);

        // Abort in IDLE blocks a simultaneous start
        w0 = writes_seen; e0 = err_seen;
        iFillStart = 1; iFillAbort = 1;
        tick();
        iFillStart = 0; iFillAbort = 0;
        check("idle_abort_busy", oFillBusy, 0);
        for (int k = 0; k < 5; k++) tick();
        check("idle_abort_writes", writes_seen - w0, 0);
        check("idle_abort_err", err_seen - e0, 0);

        // Start while busy is ignored
        w0 = writes_seen; e0 = err_seen;
        push_rect(0, 0, 3, 0, 1);
        set_rect(0, 0, 3, 0, 1);
        iFillStart = 1;
        tick();
        set_rect(10, 10, 11, 11, 7);
        tick();
        iFillStart = 0;
        wait_drain("busy_start_drain");
        check("busy_start_writes", writes_seen - w0, 4);
        check("busy_start_err", err_seen - e0, 0);

        // Reset in the middle of a long fill
        push_rect(0, 0, 31, 1, 3);
        set_rect(0, 0, 31, 1, 3);
        iFillStart = 1;
        tick();
        iFillStart = 0;
        for (int k = 0; k < 5; k++) tick();
        #1;
        Reset = 1'b0;
        sb.delete();
        #1;
        check("midrst_write", oVramWrite, 0);
        check("midrst_busy", oFillBusy, 0);
        check("midrst_done", oFillDone, 0);
        check("midrst_addr", oVramAddr, 0);
        tick();
        tick();
        Reset = 1'b1;
        w0 = writes_seen; d0 = done_seen;
        for (int k = 0; k < 10; k++) tick();
        check("postrst_writes", writes_seen - w0, 0);
        check("postrst_dones", done_seen - d0, 0);
        check("postrst_busy", oFillBusy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

endmodule
